// File: rtl/spi_child_read_12bit.sv
// Receiver for the 12-bit SCL/SS/MOSI sample link: synchronizes the link lines,
// deserializes MSB-first frames into a FWFT FIFO and counts accepted samples.
module spi_child_read_12bit #(
    parameter int FIFO_DEPTH   = 8,
    parameter int SAMPLE_LIMIT = 100
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          SCL,
    input  logic                          SS,
    input  logic                          MOSI,
    output logic [11:0]                   sample_data,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [6:0]                    rx_count,
    output logic                          done,
    output logic                          frame_err,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_t;

    logic scl_p0, scl_p1, scl_p2;
    logic ss_p0, ss_p1, ss_p2;
    logic mosi_p0, mosi_p1;

    // Synchronizer stage: _p0/_p1 are the two sync flops, _p2 is the edge reference.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_p0  <= 1'b0;
            scl_p1  <= 1'b0;
            scl_p2  <= 1'b0;
            ss_p0   <= 1'b1;
            ss_p1   <= 1'b1;
            ss_p2   <= 1'b1;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            scl_p0  <= SCL;
            scl_p1  <= scl_p0;
            scl_p2  <= scl_p1;
            ss_p0   <= SS;
            ss_p1   <= ss_p0;
            ss_p2   <= ss_p1;
            mosi_p0 <= MOSI;
            mosi_p1 <= mosi_p0;
        end
    end

    logic scl_rise, ss_fall, ss_rise;
    assign scl_rise = scl_p1 & ~scl_p2;
    assign ss_fall  = ~ss_p1 & ss_p2;
    assign ss_rise  = ss_p1 & ~ss_p2;

    state_t      state;
    logic [1:0]  settle;
    logic [11:0] shift;
    logic [4:0]  bit_cnt;
    logic [11:0] shift_next;
    logic [4:0]  cnt_next;

    logic [11:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, pop, push, eval, frame_ok;

    // A bit arriving in the same cycle as ss_rise is shifted before the frame is judged.
    always_comb begin
        shift_next = shift;
        cnt_next   = bit_cnt;
        if (scl_rise) begin
            shift_next = {shift[10:0], mosi_p1};
            if (bit_cnt != 5'd31) cnt_next = bit_cnt + 5'd1;
        end
    end

    assign sample_valid = (fifo_count != '0);
    assign sample_data  = sample_valid ? mem[rd_ptr] : 12'd0;
    assign full         = (fifo_count == CW'(FIFO_DEPTH));
    assign pop          = sample_valid & sample_ready;
    assign eval         = (state == SHIFT) & ss_rise;
    assign frame_ok     = eval & (cnt_next == 5'd12) & ~done;
    assign push         = frame_ok & (~full | pop);

    // Framing stage. The settle counter keeps WAIT_IDLE blind until the sync chain holds
    // real line samples, so a frame already running at reset release is never started.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT_IDLE;
            settle    <= 2'd0;
            shift     <= 12'd0;
            bit_cnt   <= 5'd0;
            rx_count  <= 7'd0;
            done      <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
            if (settle != 2'd3) settle <= settle + 2'd1;
            case (state)
                WAIT_IDLE: begin
                    if (settle == 2'd3 && ss_p1 && ss_p2) state <= IDLE;
                end
                IDLE: begin
                    if (ss_fall) begin
                        shift   <= 12'd0;
                        bit_cnt <= 5'd0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    shift   <= shift_next;
                    bit_cnt <= cnt_next;
                    if (ss_rise) begin
                        state     <= IDLE;
                        frame_err <= (cnt_next != 5'd12) & ~done;
                        overflow  <= frame_ok & full & ~pop;
                    end
                end
                default: state <= WAIT_IDLE;
            endcase
            if (push) begin
                rx_count <= rx_count + 7'd1;
                done     <= ((rx_count + 7'd1) == 7'(SAMPLE_LIMIT));
            end
        end
    end

    // FIFO stage: pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= shift_next;
    end

endmodule

// File: tb/tb_spi_child_read_12bit.sv
// Bench for spi_child_read_12bit: directed and random frames against a
// transaction-level model (expected-sample queue plus counters).
module tb_spi_child_read_12bit;
    localparam int DEPTH = 8;
    localparam int LIMIT = 20;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          SCL = 1'b0;
    logic          SS = 1'b1;
    logic          MOSI = 1'b0;
    logic          sample_ready = 1'b0;
    logic [11:0]   sample_data;
    logic          sample_valid;
    logic [CW-1:0] fifo_count;
    logic [6:0]    rx_count;
    logic          done, frame_err, overflow;

    spi_child_read_12bit #(.FIFO_DEPTH(DEPTH), .SAMPLE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .SCL(SCL), .SS(SS), .MOSI(MOSI),
        .sample_data(sample_data), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .fifo_count(fifo_count),
        .rx_count(rx_count), .done(done), .frame_err(frame_err),
        .overflow(overflow)
    );

    always #10 clk = ~clk;

    typedef struct {
        int          nbits;
        logic [11:0] val;
        int          cd;
    } frame_t;

    frame_t      pend[$];
    logic [11:0] q[$];
    int          m_rx = 0;
    bit          exp_err = 0, exp_ovf = 0, started = 0;
    int          n_tests = 0, n_fail = 0;
    int          n_err_pulse = 0, n_ovf_pulse = 0;
    bit          rand_ready = 0;
    int          lat;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is judged 3 clocks after SS rises on the pins; accepted frames
    // land in the queue that same edge, pops happen on any edge with valid && ready.
    always @(posedge clk) begin
        bit     pop, ev, push;
        frame_t f;
        started = 1;
        exp_err = 0;
        exp_ovf = 0;
        if (rst) begin
            q.delete();
            pend.delete();
            m_rx = 0;
        end else begin
            pop  = (q.size() != 0) && sample_ready;
            ev   = 0;
            push = 0;
            for (int i = 0; i < pend.size(); i++) pend[i].cd = pend[i].cd - 1;
            if (pend.size() != 0 && pend[0].cd == 0) begin
                f  = pend.pop_front();
                ev = 1;
            end
            if (ev && m_rx != LIMIT) begin
                if (f.nbits != 12) exp_err = 1;
                else if (q.size() == DEPTH && !pop) exp_ovf = 1;
                else begin
                    push = 1;
                    m_rx++;
                end
            end
            if (pop) void'(q.pop_front());
            if (push) q.push_back(f.val);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("valid", int'(sample_valid), int'(q.size() != 0));
            check("data", int'(sample_data), (q.size() != 0) ? int'(q[0]) : 0);
            check("fifo_count", int'(fifo_count), q.size());
            check("rx_count", int'(rx_count), m_rx);
            check("done", int'(done), int'(m_rx == LIMIT));
            check("frame_err", int'(frame_err), int'(exp_err));
            check("overflow", int'(overflow), int'(exp_ovf));
            if (frame_err) n_err_pulse++;
            if (overflow)  n_ovf_pulse++;
        end
    end

    task automatic tick();
        @(negedge clk);
        if (rand_ready) sample_ready = ($urandom_range(0, 7) == 0);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(8);
        n_err_pulse = 0;
        n_ovf_pulse = 0;
    endtask

    // Sends nbits of w MSB-first. coin: last SCL rise shares its edge with SS rise.
    // pop_eval: pulse sample_ready exactly on the clock that judges this frame.
    task automatic send_frame(input int nbits, input logic [31:0] w, input int lo,
                              input int hi, input bit coin, input bit pop_eval);
        frame_t f;
        SS = 1'b0;
        wait_cyc(lo);
        for (int i = 0; i < nbits; i++) begin
            MOSI = w[nbits-1-i];
            wait_cyc(lo);
            SCL = 1'b1;
            if (coin && i == nbits - 1) break;
            wait_cyc(hi);
            SCL = 1'b0;
        end
        if (!(coin && nbits > 0)) wait_cyc(lo);
        SS = 1'b1;
        f.nbits = nbits;
        f.val   = w[11:0];
        f.cd    = 3;
        pend.push_back(f);
        lat = -1;
        for (int i = 0; i < hi + 8; i++) begin
            tick();
            if (i + 1 == hi) SCL = 1'b0;
            if (pop_eval && i == 1) sample_ready = 1'b1;
            if (pop_eval && i == 2) sample_ready = 1'b0;
            if (lat < 0 && sample_valid) lat = i + 1;
        end
    endtask

    task automatic drain_expect(input string name, input int exp);
        check(name, int'(sample_data), exp);
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
    endtask

    initial begin
        int guard, nb, r, lo, hi;
        do_reset();
        check("reset_valid", int'(sample_valid), 0);
        check("reset_count", int'(fifo_count), 0);

        // single slow frame at link speed
        send_frame(12, 32'hA5C, 250, 250, 0, 0);
        check("t1_latency_ok", int'(lat >= 1 && lat <= 5), 1);
        check("t1_data", int'(sample_data), 'hA5C);
        check("t1_rx", int'(rx_count), 1);
        check("t1_pulses", n_err_pulse + n_ovf_pulse, 0);

        // fill past depth, one overflow, in-order drain
        do_reset();
        for (int i = 1; i <= 9; i++) send_frame(12, i, 4, 4, 0, 0);
        check("t2_count", int'(fifo_count), 8);
        check("t2_ovf_pulses", n_ovf_pulse, 1);
        check("t2_rx", int'(rx_count), 8);
        for (int i = 1; i <= 8; i++) drain_expect("t2_drain", i);
        check("t2_empty", int'(fifo_count), 0);

        // malformed lengths, then a good frame whose last bit coincides with SS rise
        do_reset();
        send_frame(11, $urandom, 5, 4, 0, 0);
        send_frame(13, $urandom, 4, 5, 0, 0);
        send_frame(12, 32'hFFF, 4, 4, 1, 0);
        check("t3_err_pulses", n_err_pulse, 2);
        check("t3_count", int'(fifo_count), 1);
        check("t3_data", int'(sample_data), 'hFFF);

        // reset in the middle of a frame
        do_reset();
        SS = 1'b0;
        wait_cyc(5);
        for (int i = 0; i < 6; i++) begin
            MOSI = 1'($urandom); wait_cyc(5); SCL = 1'b1; wait_cyc(5); SCL = 1'b0;
        end
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            MOSI = 1'($urandom); wait_cyc(5); SCL = 1'b1; wait_cyc(5); SCL = 1'b0;
        end
        wait_cyc(5);
        SS = 1'b1;
        wait_cyc(20);
        check("t4_count", int'(fifo_count), 0);
        check("t4_rx", int'(rx_count), 0);
        check("t4_pulses", n_err_pulse + n_ovf_pulse, 0);
        send_frame(12, 32'h3C3, 4, 4, 0, 0);
        check("t4_data", int'(sample_data), 'h3C3);
        check("t4_rx_after", int'(rx_count), 1);

        // push and pop on the same edge while full, with pointer wrap
        do_reset();
        for (int i = 0; i < 8; i++) send_frame(12, 32'h100 + i, 4, 4, 0, 0);
        send_frame(12, 32'h1AA, 4, 4, 0, 1);
        check("t5_count", int'(fifo_count), 8);
        check("t5_ovf_pulses", n_ovf_pulse, 0);
        for (int i = 1; i < 8; i++) drain_expect("t5_drain", 'h100 + i);
        drain_expect("t5_drain_last", 'h1AA);

        // random frames and random consumer
        do_reset();
        rand_ready = 1;
        for (int k = 0; k < 40; k++) begin
            r  = $urandom_range(0, 9);
            nb = (r < 7) ? 12 : ((r == 7) ? 0 : $urandom_range(1, 15));
            lo = $urandom_range(4, 7);
            hi = $urandom_range(4, 7);
            send_frame(nb, $urandom, lo, hi, (nb > 0) && ($urandom_range(0, 3) == 0), 0);
        end
        rand_ready = 0;
        sample_ready = 1'b0;
        wait_cyc(4);

        // sample limit reached, later frames ignored silently
        do_reset();
        sample_ready = 1'b1;
        guard = 0;
        while (m_rx < LIMIT && guard < 3 * LIMIT) begin
            send_frame(12, $urandom, 4, 4, 0, 0);
            guard++;
        end
        check("t7_done", int'(done), 1);
        check("t7_rx", int'(rx_count), LIMIT);
        n_err_pulse = 0;
        n_ovf_pulse = 0;
        send_frame(12, 32'h555, 4, 4, 0, 0);
        send_frame(5, 32'h1F, 4, 4, 0, 0);
        check("t7_silent", n_err_pulse + n_ovf_pulse, 0);
        check("t7_rx_held", int'(rx_count), LIMIT);
        check("t7_count", int'(fifo_count), 0);
        sample_ready = 1'b0;
        wait_cyc(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #(90000 * 20);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
